fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 29 ++
 rtl/fetch_unit.sv | 136 +++++++++++++
 tb/tb_fetch_unit.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if
// Instruction-memory read bus between the fetch unit and instruction memory.
//   imem_req   : fetch side requests a read (held until acked)
//   imem_addr  : word-aligned read address
//   imem_ack   : memory returns imem_rdata this cycle
//   imem_rdata : instruction word, meaningful only with imem_ack=1
// The fetch unit is the master; the memory (or a bench model) is the slave.
// ---------------------------------------------------------------------------
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Fetches one instruction at a time from instruction memory, holds it in the
// instruction register until the execute stage retires it, then computes the
// next pc (sequential, jump or taken branch) and fetches again.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   imem         : instruction-memory bus (fetch_unit_if.master)
//   instr_valid  : ir holds an instruction ready for decode/execute
//   instr_ready  : execute retires the current instruction this cycle
//   jump, branch : next-pc selection from control, sampled on retire only
//   op, func     : ir[31:26], ir[5:0]
//   rs, rt, rd   : ir[25:21], ir[20:16], ir[15:11]
//   imm16        : ir[15:0]
//   pc           : address of the instruction held in ir
//   retired      : free-running count of retired instructions (wraps)
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  fetch_unit_if.master imem,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        jump,
  input  logic        branch,
  output logic [5:0]  op,
  output logic [5:0]  func,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm16,
  output logic [31:0] pc,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } state_t;

  // Low address bits are ignored so fetches are always word aligned.
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] retired_q, retired_d;
  logic        imem_req_q, imem_req_d;
  logic        instr_valid_q, instr_valid_d;

  logic [31:0] pc4;
  logic [31:0] branch_offset;
  logic [31:0] next_pc;

  // Next-pc candidates; jump wins over branch. Both targets keep bits [1:0]
  // at zero because pc is aligned and offsets are shifted by two.
  always_comb begin
    pc4           = pc_q + 32'd4;
    branch_offset = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
    if (jump) begin
      next_pc = {pc4[31:28], ir_q[25:0], 2'b00};
    end else if (branch) begin
      next_pc = pc4 + branch_offset;
    end else begin
      next_pc = pc4;
    end
  end

  // State transitions and datapath updates. The handshake outputs are
  // computed from the next state so they can be registered and still line
  // up with the state they describe.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (imem.imem_ack) begin
          ir_d    = imem.imem_rdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (instr_ready) begin
          retired_d = retired_q + 32'd1;
          pc_d      = next_pc;
          state_d   = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    imem_req_d    = (state_d == FETCH);
    instr_valid_d = (state_d == ISSUE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC_ALIGNED;
      ir_q          <= 32'd0;
      retired_q     <= 32'd0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      retired_q     <= retired_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign imem.imem_req  = imem_req_q;
  assign imem.imem_addr = pc_q;
  assign instr_valid    = instr_valid_q;
  assign op             = ir_q[31:26];
  assign rs             = ir_q[25:21];
  assign rt             = ir_q[20:16];
  assign rd             = ir_q[15:11];
  assign func           = ir_q[5:0];
  assign imm16          = ir_q[15:0];
  assign pc             = pc_q;
  assign retired        = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit. Acts as instruction memory and execute
// stage, and keeps a transaction-level model (pc, ir, retired count) that is
// advanced once per fetched / retired instruction.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        instr_ready;
  logic        jump;
  logic        branch;
  logic        instr_valid;
  logic [5:0]  op;
  logic [5:0]  func;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm16;
  logic [31:0] pc;
  logic [31:0] retired;

  fetch_unit_if imem_bus ();

  // A misaligned reset address exercises the forced-zero low bits; the
  // effective first fetch address is still 0.
  fetch_unit #(
    .RESET_PC (32'h0000_0003)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem        (imem_bus.master),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .jump        (jump),
    .branch      (branch),
    .op          (op),
    .func        (func),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .imm16       (imm16),
    .pc          (pc),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  int n_asserts = 0;
  int n_failures = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_ir;
  logic [31:0] m_retired;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_failures++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic ack, input logic [31:0] rdata,
                               input logic ready, input logic j, input logic b);
    imem_bus.imem_ack   = ack;
    imem_bus.imem_rdata = rdata;
    instr_ready         = ready;
    jump                = j;
    branch              = b;
  endtask

  function automatic logic [31:0] modelNextPc(input logic [31:0] cur_pc, input logic [31:0] word,
                                              input logic j, input logic b);
    logic [31:0]        seq;
    logic signed [15:0] s16;
    int                 off;
    seq = cur_pc + 32'd4;
    s16 = word[15:0];
    off = int'(s16) * 4;
    if (j) return {seq[31:28], word[25:0], 2'b00};
    if (b) return seq + 32'(off);
    return seq;
  endfunction

  task automatic modelReset();
    m_pc      = 32'h0000_0000;
    m_ir      = 32'h0000_0000;
    m_retired = 32'h0000_0000;
  endtask

  task automatic checkIr(input string tag);
    checkOutput({tag, "_ir"}, {op, rs, rt, imm16}, m_ir);
    checkOutput({tag, "_rd"}, {27'd0, rd}, {27'd0, m_ir[15:11]});
    checkOutput({tag, "_func"}, {26'd0, func}, {26'd0, m_ir[5:0]});
  endtask

  // Entered at a negedge with the DUT in FETCH; leaves at a negedge in ISSUE.
  task automatic fetchPhase(input int wait_cycles, input logic [31:0] word);
    checkOutput("fetch_req", {31'd0, imem_bus.imem_req}, 32'd1);
    checkOutput("fetch_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("fetch_addr", imem_bus.imem_addr, m_pc);
    for (int i = 0; i < wait_cycles; i++) begin
      applyStimulus(1'b0, $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
      @(posedge clk);
      @(negedge clk);
      checkOutput("wait_req", {31'd0, imem_bus.imem_req}, 32'd1);
      checkOutput("wait_addr", imem_bus.imem_addr, m_pc);
      checkOutput("wait_pc", pc, m_pc);
      checkOutput("wait_retired", retired, m_retired);
    end
    applyStimulus(1'b1, word, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(1'b0, $urandom, 1'b0, 1'b0, 1'b0);
    m_ir = word;
    checkOutput("issue_valid", {31'd0, instr_valid}, 32'd1);
    checkOutput("issue_req", {31'd0, imem_bus.imem_req}, 32'd0);
    checkOutput("issue_pc", pc, m_pc);
    checkIr("issue");
  endtask

  // Entered at a negedge in ISSUE; leaves at a negedge in FETCH.
  task automatic retirePhase(input int stall_cycles, input logic j, input logic b);
    for (int i = 0; i < stall_cycles; i++) begin
      applyStimulus(1'($urandom), $urandom, 1'b0, 1'($urandom), 1'($urandom));
      @(posedge clk);
      @(negedge clk);
      checkOutput("stall_valid", {31'd0, instr_valid}, 32'd1);
      checkOutput("stall_req", {31'd0, imem_bus.imem_req}, 32'd0);
      checkOutput("stall_pc", pc, m_pc);
      checkOutput("stall_retired", retired, m_retired);
      checkIr("stall");
    end
    applyStimulus(1'b0, $urandom, 1'b1, j, b);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(1'b0, $urandom, 1'b0, 1'b0, 1'b0);
    m_pc      = modelNextPc(m_pc, m_ir, j, b);
    m_retired = m_retired + 32'd1;
    checkOutput("retire_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("retire_req", {31'd0, imem_bus.imem_req}, 32'd1);
    checkOutput("retire_addr", imem_bus.imem_addr, m_pc);
    checkOutput("retire_count", retired, m_retired);
  endtask

  // Releases reset just after a rising edge, checks the single IDLE cycle,
  // and leaves at the negedge of the first FETCH cycle.
  task automatic releaseReset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_req", {31'd0, imem_bus.imem_req}, 32'd0);
    checkOutput("idle_valid", {31'd0, instr_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("first_req", {31'd0, imem_bus.imem_req}, 32'd1);
    checkOutput("first_addr", imem_bus.imem_addr, 32'h0000_0000);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] word;
    logic        rj;
    logic        rb;

    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    modelReset();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_req", {31'd0, imem_bus.imem_req}, 32'd0);
    checkOutput("rst_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("rst_pc", pc, 32'h0000_0000);
    checkOutput("rst_retired", retired, 32'd0);
    checkIr("rst");
    repeat (2) @(posedge clk);
    releaseReset();

    // addi with zero-wait ack, immediate retire
    fetchPhase(0, 32'h2008_0005);
    checkOutput("addi_op", {26'd0, op}, 32'h0000_0008);
    checkOutput("addi_rt", {27'd0, rt}, 32'd8);
    checkOutput("addi_imm", {16'd0, imm16}, 32'h0000_0005);
    retirePhase(0, 1'b0, 1'b0);

    // three wait cycles on memory, four stall cycles on execute
    fetchPhase(3, 32'h0123_4567);
    retirePhase(4, 1'b0, 1'b0);
    checkOutput("stall_release_count", retired, 32'd2);

    // nop at 0x8, filler at 0xC, then jump at 0x10
    fetchPhase(1, 32'h0000_0000);
    retirePhase(1, 1'b0, 1'b0);
    fetchPhase(0, 32'h2129_0001);
    retirePhase(0, 1'b0, 1'b0);
    fetchPhase(1, 32'h0800_0040);
    retirePhase(0, 1'b1, 1'b0);
    checkOutput("jump_target", imem_bus.imem_addr, 32'h0000_0100);
    fetchPhase(0, 32'h0800_0004);
    retirePhase(0, 1'b1, 1'b0);
    fetchPhase(0, 32'h0800_0040);
    retirePhase(0, 1'b1, 1'b1);
    checkOutput("jump_over_branch", imem_bus.imem_addr, 32'h0000_0100);

    // branches at 0x20: backward to 0x1C, then forward to 0x30
    fetchPhase(0, 32'h0800_0008);
    retirePhase(0, 1'b1, 1'b0);
    fetchPhase(0, 32'h1000_FFFE);
    retirePhase(0, 1'b0, 1'b1);
    checkOutput("branch_back", imem_bus.imem_addr, 32'h0000_001C);
    fetchPhase(0, 32'h0800_0008);
    retirePhase(0, 1'b1, 1'b0);
    fetchPhase(0, 32'h1000_0003);
    retirePhase(0, 1'b0, 1'b1);
    checkOutput("branch_fwd", imem_bus.imem_addr, 32'h0000_0030);

    // random words, latencies and control decisions
    for (int n = 0; n < 40; n++) begin
      word = $urandom;
      rj   = ($urandom_range(0, 3) == 0);
      rb   = ($urandom_range(0, 2) == 0);
      fetchPhase(int'($urandom_range(0, 3)), word);
      retirePhase(int'($urandom_range(0, 3)), rj, rb);
    end

    // retired counter wrap: preload all-ones while waiting in FETCH
    force dut.retired_q = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.retired_q;
    m_retired = 32'hFFFF_FFFF;
    checkOutput("retired_preload", retired, 32'hFFFF_FFFF);
    fetchPhase(0, $urandom);
    retirePhase(0, 1'b0, 1'b0);
    checkOutput("retired_wrap", retired, 32'h0000_0000);

    // reset asserted mid-ISSUE with instr_ready high
    fetchPhase(1, 32'hAAAA_5555);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_issue_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("rst_issue_retired", retired, 32'd0);
    checkOutput("rst_issue_pc", pc, 32'h0000_0000);
    modelReset();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    releaseReset();

    // retire one so ir/pc/retired are non-zero, then reset mid-FETCH
    fetchPhase(0, 32'h8C43_0010);
    retirePhase(0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_fetch_req", {31'd0, imem_bus.imem_req}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    modelReset();
    checkIr("rst_fetch");
    checkOutput("rst_fetch_pc", pc, 32'h0000_0000);
    checkOutput("rst_fetch_retired", retired, 32'd0);
    checkOutput("rst_fetch_valid", {31'd0, instr_valid}, 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    releaseReset();

    // straight-line run at full throughput: two cycles per instruction
    for (int n = 0; n < 1000; n++) begin
      checkOutput("seq_addr", imem_bus.imem_addr, 32'(n) * 32'd4);
      fetchPhase(0, $urandom);
      retirePhase(0, 1'b0, 1'b0);
    end
    checkOutput("seq_retired", retired, 32'd1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_failures);
    $finish;
  end

endmodule
